// File: rtl/uart_rx_os.sv
// Oversampled UART receiver with majority-vote bit recovery and a one-entry valid/ready holding register.
// Optional parity support is built when UART_RX_PARITY_EN is defined.
module uart_rx_os #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rx_en,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 stop2,
`ifdef UART_RX_PARITY_EN
    input  logic                 par_en,
    input  logic                 par_odd,
`endif
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 par_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int OS_W  = $clog2(OS_RATE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [OS_W-1:0]  OS_SAMP0 = OS_W'(OS_RATE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_SAMP1 = OS_W'(OS_RATE / 2);
    localparam logic [OS_W-1:0]  OS_VOTE  = OS_W'(OS_RATE / 2 + 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DELIVER
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_s_q, rx_s_d;
    logic                   rx_prev_q, rx_prev_d;
    logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
    logic [OS_W-1:0]        os_cnt_q, os_cnt_d;
    logic [1:0]             samp_q, samp_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   ferr_acc_q, ferr_acc_d;
    logic                   perr_acc_q, perr_acc_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   par_err_q, par_err_d;
    logic                   overrun_q, overrun_d;

    logic tick;
    logic vote;
    logic vote_now;
    logic bit_end;

    assign tick     = (tick_cnt_q == '0);
    assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
    assign vote_now = (state_q != S_IDLE) && tick && (os_cnt_q == OS_VOTE);
    assign bit_end  = tick && (os_cnt_q == OS_LAST);

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        state_d     = state_q;
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        rx_prev_d   = rx_s_q;
        tick_cnt_d  = (state_q == S_IDLE || tick) ? baud_div : tick_cnt_q - DIV_WIDTH'(1);
        os_cnt_d    = os_cnt_q;
        samp_d      = samp_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        stop_idx_d  = stop_idx_q;
        ferr_acc_d  = ferr_acc_q;
        perr_acc_d  = perr_acc_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        par_err_d   = par_err_q;
        overrun_d   = 1'b0;

        if (state_q != S_IDLE && tick) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            if (os_cnt_q == OS_SAMP0) samp_d[0] = rx_s_q;
            if (os_cnt_q == OS_SAMP1) samp_d[1] = rx_s_q;
        end

        if (valid_q && ready) valid_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                os_cnt_d = '0;
                if (rx_en && rx_prev_q && !rx_s_q) begin
                    state_d    = S_START;
                    bit_cnt_d  = '0;
                    stop_idx_d = 1'b0;
                    ferr_acc_d = 1'b0;
                    perr_acc_d = 1'b0;
                end
            end
            S_START: begin
                if (vote_now && vote) state_d = S_IDLE;
                else if (bit_end)     state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_now) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = par_en ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                // Even parity: data XOR parity bit must be 0; odd parity flips the sense.
                if (vote_now) perr_acc_d = (^shreg_q) ^ vote ^ par_odd;
                if (bit_end)  state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // The frame closes at the vote of the last stop bit, not at its bit end.
                if (vote_now) begin
                    ferr_acc_d = ferr_acc_q | !vote;
                    if (stop2 && !stop_idx_q) stop_idx_d = 1'b1;
                    else                      state_d    = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
                if (!valid_q || ready) begin
                    data_d      = shreg_q;
                    frame_err_d = ferr_acc_q;
                    par_err_d   = perr_acc_q;
                    valid_d     = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!rx_en && state_q != S_IDLE && state_q != S_DELIVER) state_d = S_IDLE;

        if (rst) begin
            state_d     = S_IDLE;
            rx_meta_d   = 1'b1;
            rx_s_d      = 1'b1;
            rx_prev_d   = 1'b1;
            tick_cnt_d  = '0;
            os_cnt_d    = '0;
            samp_d      = '0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            stop_idx_d  = 1'b0;
            ferr_acc_d  = 1'b0;
            perr_acc_d  = 1'b0;
            data_d      = '0;
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
            par_err_d   = 1'b0;
            overrun_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= S_IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            tick_cnt_q  <= '0;
            os_cnt_q    <= '0;
            samp_q      <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            stop_idx_q  <= 1'b0;
            ferr_acc_q  <= 1'b0;
            perr_acc_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            tick_cnt_q  <= tick_cnt_d;
            os_cnt_q    <= os_cnt_d;
            samp_q      <= samp_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            stop_idx_q  <= stop_idx_d;
            ferr_acc_q  <= ferr_acc_d;
            perr_acc_q  <= perr_acc_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign par_err   = par_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed self-checking bench for uart_rx_os: frames, errors, glitch rejection, overrun, aborts and resets.
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_os;

    localparam int DATA_BITS = 8;
    localparam int OS_RATE   = 16;
    localparam int DIV_WIDTH = 16;
    // Posedges from the start-bit negedge to the DELIVER cycle of an 8N1 frame at baud_div=0.
    localparam int DELIVER_EDGE = 4 + OS_RATE * (DATA_BITS + 1) + OS_RATE / 2 + 1;

    logic                 clk = 1'b0;
    logic                 arst_n = 1'b0;
    logic                 rst = 1'b0;
    logic                 rx = 1'b1;
    logic                 rx_en = 1'b1;
    logic [DIV_WIDTH-1:0] baud_div = '0;
    logic                 stop2 = 1'b0;
    logic                 par_en = 1'b0;
    logic                 par_odd = 1'b0;
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready = 1'b0;
    logic                 frame_err;
    logic                 par_err;
    logic                 overrun;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_BITS(DATA_BITS), .OS_RATE(OS_RATE), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .rst       (rst),
        .rx        (rx),
        .rx_en     (rx_en),
        .baud_div  (baud_div),
        .stop2     (stop2),
`ifdef UART_RX_PARITY_EN
        .par_en    (par_en),
        .par_odd   (par_odd),
`endif
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .par_err   (par_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    task automatic tick_neg();
        @(negedge clk);
        if (overrun === 1'b1) ovr_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_neg();
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(OS_RATE * (int'(baud_div) + 1));
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input logic has_par, input logic pbit,
                              input logic stop_a, input logic stop_b);
        tick_neg();
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        if (has_par) drive_bit(pbit);
        drive_bit(stop_a);
        if (stop2) drive_bit(stop_b);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (valid !== 1'b1 && n < 8) begin
            tick_neg();
            n++;
        end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout: valid=%b after %0d cycles, expected 1", name, valid, n);
        end
    endtask

    task automatic consume();
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        idle(3);
        arst_n = 1'b1;
        idle(2);
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
        checks++; if (data !== '0)        begin errors++; $display("FAIL reset_data: got %h exp 00", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        checks++; if (par_err !== 1'b0)   begin errors++; $display("FAIL reset_par_err: got %b exp 0", par_err); end
        checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    endtask

    task automatic test_basic();
        baud_div = 16'd0;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_valid("basic");
        checks++; if (data !== 8'hA5)     begin errors++; $display("FAIL basic_data: got %h exp a5", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b exp 0", frame_err); end
        checks++; if (par_err !== 1'b0)   begin errors++; $display("FAIL basic_par_err: got %b exp 0", par_err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL basic_busy: got %b exp 0", busy); end
        consume();
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL basic_pop_valid: got %b exp 0", valid); end
        checks++; if (data !== 8'hA5)     begin errors++; $display("FAIL basic_pop_hold: got %h exp a5", data); end
        idle(10);
    endtask

    task automatic test_frame_err();
        baud_div = 16'd1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_valid("ferr1");
        checks++; if (data !== 8'h3C)     begin errors++; $display("FAIL ferr1_data: got %h exp 3c", data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr1_flag: got %b exp 1", frame_err); end
        consume();
        idle(20);
        stop2 = 1'b1;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_valid("ferr2");
        checks++; if (data !== 8'h81)     begin errors++; $display("FAIL ferr2_data: got %h exp 81", data); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr2_flag: got %b exp 1", frame_err); end
        consume();
        idle(20);
        send_frame(8'h42, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_valid("stop2_ok");
        checks++; if (data !== 8'h42)     begin errors++; $display("FAIL stop2_ok_data: got %h exp 42", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL stop2_ok_flag: got %b exp 0", frame_err); end
        consume();
        stop2 = 1'b0;
        baud_div = 16'd0;
        idle(20);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        par_en  = 1'b1;
        par_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_valid("par_bad");
        checks++; if (data !== 8'h07)   begin errors++; $display("FAIL par_bad_data: got %h exp 07", data); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b exp 1", par_err); end
        consume();
        idle(10);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_valid("par_ok");
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_ok_flag: got %b exp 0", par_err); end
        consume();
        par_en = 1'b0;
        idle(10);
    endtask
`endif

    task automatic test_glitch();
        logic saw_busy;
        int   n;
        saw_busy = 1'b0;
        n = 0;
        tick_neg();
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        while (n < 40 && !(saw_busy && busy === 1'b0)) begin
            tick_neg();
            if (busy === 1'b1) saw_busy = 1'b1;
            n++;
        end
        checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_start: busy seen=%b exp 1", saw_busy); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL glitch_idle: busy=%b exp 0", busy); end
        idle(OS_RATE * 11);
        checks++; if (valid !== 1'b0)    begin errors++; $display("FAIL glitch_valid: got %b exp 0", valid); end
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_valid("b2b_first");
        idle(10);
        ovr_cnt = 0;
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(10);
        checks++; if (ovr_cnt !== 1)   begin errors++; $display("FAIL b2b_overrun_count: got %0d exp 1", ovr_cnt); end
        checks++; if (data !== 8'h11)  begin errors++; $display("FAIL b2b_held_data: got %h exp 11", data); end
        checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL b2b_held_valid: got %b exp 1", valid); end
        ovr_cnt = 0;
        fork
            send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b1);
            begin
                @(negedge clk);
                repeat (DELIVER_EDGE) @(posedge clk);
                @(negedge clk);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        idle(10);
        checks++; if (ovr_cnt !== 0)   begin errors++; $display("FAIL b2b_swap_overrun: got %0d exp 0", ovr_cnt); end
        checks++; if (data !== 8'h33)  begin errors++; $display("FAIL b2b_swap_data: got %h exp 33", data); end
        checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL b2b_swap_valid: got %b exp 1", valid); end
    endtask

    task automatic test_rx_en_abort();
        tick_neg();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        rx_en = 1'b0;
        tick_neg();
        checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy: got %b exp 0", busy); end
        rx = 1'b1;
        idle(OS_RATE * 8);
        checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL abort_valid: got %b exp 1", valid); end
        checks++; if (data !== 8'h33)  begin errors++; $display("FAIL abort_data: got %h exp 33", data); end
        rx_en = 1'b1;
        idle(5);
    endtask

    task automatic test_reset_mid();
        tick_neg();
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        arst_n = 1'b0;
        rx = 1'b1;
        #1;
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL arst_valid: got %b exp 0", valid); end
        checks++; if (data !== '0)        begin errors++; $display("FAIL arst_data: got %h exp 00", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL arst_frame_err: got %b exp 0", frame_err); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL arst_busy: got %b exp 0", busy); end
        idle(3);
        arst_n = 1'b1;
        idle(5);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_valid("post_arst");
        checks++; if (data !== 8'h5A)     begin errors++; $display("FAIL post_arst_data: got %h exp 5a", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL post_arst_frame_err: got %b exp 0", frame_err); end
        idle(5);
        rst = 1'b1;
        tick_neg();
        rst = 1'b0;
        tick_neg();
        checks++; if (valid !== 1'b0)     begin errors++; $display("FAIL srst_valid: got %b exp 0", valid); end
        checks++; if (data !== '0)        begin errors++; $display("FAIL srst_data: got %h exp 00", data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_glitch();
        test_back_to_back();
        test_rx_en_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
